// File: rtl/alu_pkg.sv
// Shared ALU control codes and sequencer state type for the execute-stage ALU sharing logic.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MOVE = 3'b010;
    localparam logic [2:0] ALU_SWAP = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SWAP2
    } seq_state_t;

    // Only arithmetic ops report overflow to the exception logic.
    function automatic logic ovf_tracked(input logic [2:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of requester, ALU and write-back signals around the shared ALU sequencer.
interface alu_sequencer_if #(
    parameter int REG_W = 4
);

    logic             Req0Valid;
    logic             Req0Ready;
    logic [2:0]       Req0Ctrl;
    logic [15:0]      Req0A;
    logic [15:0]      Req0B;
    logic [REG_W-1:0] Req0Dest;
    logic [REG_W-1:0] Req0Dest2;

    logic             Req1Valid;
    logic             Req1Ready;
    logic [2:0]       Req1Ctrl;
    logic [15:0]      Req1A;
    logic [15:0]      Req1B;
    logic [REG_W-1:0] Req1Dest;
    logic [REG_W-1:0] Req1Dest2;

    logic [15:0]      AluOp1;
    logic [15:0]      AluOp2;
    logic [2:0]       AluControl;
    logic [31:0]      AluResult;
    logic             AluOverflow;

    logic             RspValid;
    logic             RspId;
    logic [REG_W-1:0] RspReg;
    logic [15:0]      RspData;
    logic             RspOvf;
    logic             OvfStatus;
    logic             OvfClear;

    modport slave (
        input  Req0Valid, Req0Ctrl, Req0A, Req0B, Req0Dest, Req0Dest2,
        output Req0Ready,
        input  Req1Valid, Req1Ctrl, Req1A, Req1B, Req1Dest, Req1Dest2,
        output Req1Ready,
        output AluOp1, AluOp2, AluControl,
        input  AluResult, AluOverflow,
        output RspValid, RspId, RspReg, RspData, RspOvf, OvfStatus,
        input  OvfClear
    );

    modport master (
        output Req0Valid, Req0Ctrl, Req0A, Req0B, Req0Dest, Req0Dest2,
        input  Req0Ready,
        output Req1Valid, Req1Ctrl, Req1A, Req1B, Req1Dest, Req1Dest2,
        input  Req1Ready,
        input  AluOp1, AluOp2, AluControl,
        output AluResult, AluOverflow,
        input  RspValid, RspId, RspReg, RspData, RspOvf, OvfStatus,
        output OvfClear
    );

endinterface

// File: rtl/alu_sequencer_arb.sv
// Two-way round-robin arbiter; the last-grant history lives in the caller.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one 16-bit ALU between the EX stage and the aux unit; SWAP writes back in two beats.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int REG_W = 4
) (
    input logic             clk,
    input logic             rst,
    alu_sequencer_if.slave  bus
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic             last_grant;
    logic [1:0]       grant;
    logic             accept;
    logic             beat_ovf;

    logic             sel;
    logic [2:0]       sel_ctrl;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic [REG_W-1:0] sel_dest;
    logic [REG_W-1:0] sel_dest2;

    logic [2:0]       ctrl_q;
    logic             id_q;
    logic [REG_W-1:0] dest_q;
    logic [REG_W-1:0] dest2_q;
    logic [15:0]      upper_q;

    rr_arbiter2 u_arb (
        .req    ({bus.Req1Valid, bus.Req0Valid}),
        .last   (last_grant),
        .enable (state == IDLE),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = (ctrl_q == ALU_SWAP) ? SWAP2 : IDLE;
            SWAP2:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The arbiter is only enabled in IDLE, so a grant already implies Ready.
    always_comb begin
        bus.Req0Ready = grant[0];
        bus.Req1Ready = grant[1];
        accept        = |grant;
        sel           = grant[1];
        sel_ctrl      = sel ? bus.Req1Ctrl  : bus.Req0Ctrl;
        sel_a         = sel ? bus.Req1A     : bus.Req0A;
        sel_b         = sel ? bus.Req1B     : bus.Req0B;
        sel_dest      = sel ? bus.Req1Dest  : bus.Req0Dest;
        sel_dest2     = sel ? bus.Req1Dest2 : bus.Req0Dest2;
        beat_ovf      = (state == EXEC) && ovf_tracked(ctrl_q) && bus.AluOverflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant     <= 1'b1;
            ctrl_q         <= '0;
            id_q           <= 1'b0;
            dest_q         <= '0;
            dest2_q        <= '0;
            upper_q        <= '0;
            bus.AluOp1     <= '0;
            bus.AluOp2     <= '0;
            bus.AluControl <= '0;
            bus.RspValid   <= 1'b0;
            bus.RspId      <= 1'b0;
            bus.RspReg     <= '0;
            bus.RspData    <= '0;
            bus.RspOvf     <= 1'b0;
        end else begin
            bus.RspValid <= 1'b0;
            if (accept) begin
                ctrl_q         <= sel_ctrl;
                id_q           <= sel;
                dest_q         <= sel_dest;
                dest2_q        <= sel_dest2;
                last_grant     <= sel;
                bus.AluOp1     <= sel_a;
                bus.AluOp2     <= sel_b;
                bus.AluControl <= sel_ctrl;
            end
            case (state)
                EXEC: begin
                    bus.RspValid <= 1'b1;
                    bus.RspId    <= id_q;
                    bus.RspReg   <= dest_q;
                    bus.RspData  <= bus.AluResult[15:0];
                    bus.RspOvf   <= beat_ovf;
                    upper_q      <= bus.AluResult[31:16];
                end
                SWAP2: begin
                    bus.RspValid <= 1'b1;
                    bus.RspId    <= id_q;
                    bus.RspReg   <= dest2_q;
                    bus.RspData  <= upper_q;
                    bus.RspOvf   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A new overflow beat takes priority over a coincident clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.OvfStatus <= 1'b0;
        end else if (beat_ovf) begin
            bus.OvfStatus <= 1'b1;
        end else if (bus.OvfClear) begin
            bus.OvfStatus <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural MainALU and randomized two-requester traffic.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int REG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_sequencer_if #(.REG_W(REG_W)) bus ();

    alu_sequencer #(.REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // MainALU: signed overflow for ADD/SUB, deliberately noisy flag for other ops
    logic [15:0] alu_sum;
    logic [15:0] alu_diff;
    always_comb begin
        alu_sum         = bus.AluOp1 + bus.AluOp2;
        alu_diff        = bus.AluOp1 - bus.AluOp2;
        bus.AluResult   = '0;
        bus.AluOverflow = 1'b0;
        case (bus.AluControl)
            3'b000: begin
                bus.AluResult   = {16'h0000, alu_sum};
                bus.AluOverflow = (bus.AluOp1[15] == bus.AluOp2[15]) && (alu_sum[15] != bus.AluOp1[15]);
            end
            3'b001: begin
                bus.AluResult   = {16'h0000, alu_diff};
                bus.AluOverflow = (bus.AluOp1[15] != bus.AluOp2[15]) && (alu_diff[15] != bus.AluOp1[15]);
            end
            3'b010:  bus.AluResult = {16'h0000, bus.AluOp2};
            3'b011:  bus.AluResult = {bus.AluOp1, bus.AluOp2};
            3'b100:  bus.AluResult = {16'h0000, bus.AluOp1 & bus.AluOp2};
            default: bus.AluResult = {16'h0000, bus.AluOp1 | bus.AluOp2};
        endcase
        if (bus.AluControl > 3'b001) bus.AluOverflow = ^bus.AluResult[15:0];
    end

    typedef struct {
        int unsigned due;
        logic        id;
        logic [3:0]  rg;
        logic [15:0] data;
        logic        ovf;
    } beat_t;

    beat_t       exp_q[$];
    int          grant_log[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int          m_busy = 0;
    logic        m_last = 1'b1;
    logic        m_ovf = 1'b0;
    logic        rst_prev = 1'b1;
    logic        clear_prev = 1'b0;
    logic        rnd_done = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: results computed from plain integer arithmetic on the op definitions.
    function automatic void ref_push(input logic id, input logic [2:0] ctrl, input logic [15:0] a,
                                     input logic [15:0] b, input logic [3:0] d, input logic [3:0] d2);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int r = 0;
        logic [15:0] data = '0;
        logic ovf = 1'b0;
        case (ctrl)
            3'd0: begin r = sa + sb; data = r[15:0]; ovf = (r > 32767) || (r < -32768); end
            3'd1: begin r = sa - sb; data = r[15:0]; ovf = (r > 32767) || (r < -32768); end
            3'd2: data = b;
            3'd3: data = b;
            3'd4: data = a & b;
            default: data = a | b;
        endcase
        exp_q.push_back('{cyc + 2, id, d, data, ovf});
        if (ctrl == 3'd3) exp_q.push_back('{cyc + 3, id, d2, a, 1'b0});
    endfunction

    // Monitor: readiness/arbitration model, beat scoreboard and sticky-flag model
    always @(negedge clk) begin
        logic  exp_r0;
        logic  exp_r1;
        logic  beat_ovf;
        beat_t e;
        cyc++;
        beat_ovf = 1'b0;
        if (rst_prev) begin
            exp_q.delete();
            m_last = 1'b1;
            m_busy = 0;
            m_ovf  = 1'b0;
            chk("rst_rspvalid", {31'd0, bus.RspValid}, 0);
            chk("rst_rspid", {31'd0, bus.RspId}, 0);
            chk("rst_rspreg", {28'd0, bus.RspReg}, 0);
            chk("rst_rspdata", {16'd0, bus.RspData}, 0);
            chk("rst_rspovf", {31'd0, bus.RspOvf}, 0);
            chk("rst_aluop1", {16'd0, bus.AluOp1}, 0);
            chk("rst_aluop2", {16'd0, bus.AluOp2}, 0);
            chk("rst_aluctl", {29'd0, bus.AluControl}, 0);
        end else if (m_busy > 0) begin
            m_busy--;
        end
        exp_r0 = (m_busy == 0) && bus.Req0Valid && (!bus.Req1Valid || m_last);
        exp_r1 = (m_busy == 0) && bus.Req1Valid && (!bus.Req0Valid || !m_last);
        chk("ready0", {31'd0, bus.Req0Ready}, {31'd0, exp_r0});
        chk("ready1", {31'd0, bus.Req1Ready}, {31'd0, exp_r1});
        if (bus.RspValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", {31'd0, bus.RspValid}, 0);
            end else begin
                e = exp_q.pop_front();
                beat_ovf = e.ovf;
                chk("beat_cycle", cyc, e.due);
                chk("beat_id", {31'd0, bus.RspId}, {31'd0, e.id});
                chk("beat_reg", {28'd0, bus.RspReg}, {28'd0, e.rg});
                chk("beat_data", {16'd0, bus.RspData}, {16'd0, e.data});
                chk("beat_ovf", {31'd0, bus.RspOvf}, {31'd0, e.ovf});
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_beat", {31'd0, bus.RspValid}, 1);
        end
        if (!rst_prev) begin
            if (beat_ovf) m_ovf = 1'b1;
            else if (clear_prev) m_ovf = 1'b0;
        end
        chk("ovf_status", {31'd0, bus.OvfStatus}, {31'd0, m_ovf});
        if (!rst) begin
            if (exp_r0) begin
                ref_push(1'b0, bus.Req0Ctrl, bus.Req0A, bus.Req0B, bus.Req0Dest, bus.Req0Dest2);
                m_last = 1'b0;
                m_busy = (bus.Req0Ctrl == 3'd3) ? 3 : 2;
                grant_log.push_back(0);
            end else if (exp_r1) begin
                ref_push(1'b1, bus.Req1Ctrl, bus.Req1A, bus.Req1B, bus.Req1Dest, bus.Req1Dest2);
                m_last = 1'b1;
                m_busy = (bus.Req1Ctrl == 3'd3) ? 3 : 2;
                grant_log.push_back(1);
            end
        end
        rst_prev   = rst;
        clear_prev = bus.OvfClear;
    end

    // Called just after a rising edge; returns just after the edge that follows acceptance.
    task automatic send(input int id, input logic [2:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] d, input logic [3:0] d2);
        bit done = 0;
        if (id == 0) begin
            bus.Req0Valid = 1'b1; bus.Req0Ctrl = ctrl; bus.Req0A = a; bus.Req0B = b;
            bus.Req0Dest = d; bus.Req0Dest2 = d2;
        end else begin
            bus.Req1Valid = 1'b1; bus.Req1Ctrl = ctrl; bus.Req1A = a; bus.Req1B = b;
            bus.Req1Dest = d; bus.Req1Dest2 = d2;
        end
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = (id == 0) ? bus.Req0Ready : bus.Req1Ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        if (id == 0) bus.Req0Valid = 1'b0;
        else bus.Req1Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic rnd_requester(input int id);
        for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 2));
            send(id, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        bus.Req0Valid = 1'b0; bus.Req0Ctrl = '0; bus.Req0A = '0; bus.Req0B = '0;
        bus.Req0Dest = '0; bus.Req0Dest2 = '0;
        bus.Req1Valid = 1'b0; bus.Req1Ctrl = '0; bus.Req1A = '0; bus.Req1B = '0;
        bus.Req1Dest = '0; bus.Req1Dest2 = '0;
        bus.OvfClear = 1'b0;
        idle(3);
        rst = 1'b0;

        send(0, ALU_ADD, 16'h0003, 16'h0004, 4'd5, 4'd0);
        idle(3);
        send(1, ALU_SUB, 16'h8000, 16'h0001, 4'd7, 4'd0);
        idle(4);
        @(negedge clk);
        chk("ovf_held", {31'd0, bus.OvfStatus}, 1);
        @(posedge clk); #1;
        bus.OvfClear = 1'b1;
        idle(1);
        bus.OvfClear = 1'b0;
        send(0, ALU_SWAP, 16'h1111, 16'h2222, 4'd2, 4'd3);
        idle(4);

        do_reset();
        grant_log.delete();
        fork
            begin send(0, ALU_ADD, 16'h0010, 16'h0001, 4'd1, 4'd0); send(0, ALU_ADD, 16'h7FFF, 16'h0001, 4'd2, 4'd0); end
            begin send(1, ALU_ADD, 16'h0020, 16'h0002, 4'd3, 4'd0); send(1, ALU_ADD, 16'hFFFF, 16'h0001, 4'd4, 4'd0); end
        join
        chk("rr_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % 2);
        idle(3);

        send(0, ALU_SWAP, 16'hABCD, 16'h1234, 4'd8, 4'd9);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        grant_log.delete();
        fork
            send(0, ALU_OR, 16'h00F0, 16'h000F, 4'd6, 4'd0);
            send(1, ALU_AND, 16'h00F0, 16'h0FFF, 4'd7, 4'd0);
        join
        chk("post_rst_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        idle(3);

        send(1, ALU_SUB, 16'h8000, 16'h0001, 4'd4, 4'd0);
        bus.OvfClear = 1'b1;
        idle(1);
        @(negedge clk);
        chk("ovf_set_wins", {31'd0, bus.OvfStatus}, 1);
        @(posedge clk); #1;
        bus.OvfClear = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", {31'd0, bus.OvfStatus}, 0);
        @(posedge clk); #1;

        fork
            begin
                fork
                    rnd_requester(0);
                    rnd_requester(1);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.OvfClear = ($urandom_range(0, 7) == 0);
                    idle(1);
                end
                bus.OvfClear = 1'b0;
            end
        join
        idle(6);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
